chunked_serial_adder: RTL



---
 rtl/chunked_adder_pkg.sv | 19 +
 rtl/chunk_adder.sv | 30 +++
 rtl/chunked_serial_adder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/chunked_adder_pkg.sv
// Shared types and helpers for the chunked serial adder.
package chunked_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of the slice counter; never less than one bit.
    function automatic int cnt_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry slice; also exposes the carry into the
// slice MSB so the top can form signed overflow on the last slice.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c_s;

    // Ripple of full-adder cells across the slice.
    always_comb begin
        c_s    = '0;
        s      = '0;
        c_s[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]     = a[i] ^ b[i] ^ c_s[i];
            c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c_s[CHUNK];
    assign c_msb = c_s[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: WIDTH-bit operands summed CHUNK bits per clock, LSB first.
// Optional subtract mode (port `sub`) under macro CHUNKED_SERIAL_ADDER_SUB_EN.
module chunked_serial_adder
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NCHUNK = (CHUNK < 1) ? 1 : (WIDTH / CHUNK);
    localparam int CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if (((CHUNK < 1) ? 1 : (WIDTH % CHUNK)) != 0) begin : g_bad_chunk
        $error("chunked_serial_adder: CHUNK must be >= 1 and divide WIDTH");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic              carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              sub_s;
    logic [CHUNK-1:0]  slice_sum_s;
    logic              slice_cout_s, slice_cmsb_s;

`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    assign sub_s = sub;
`else
    assign sub_s = 1'b0;
`endif

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_q[CHUNK-1:0]),
        .b     (b_q[CHUNK-1:0]),
        .cin   (carry_q),
        .s     (slice_sum_s),
        .cout  (slice_cout_s),
        .c_msb (slice_cmsb_s)
    );

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub_s}};
                    carry_d = cin ^ sub_s;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                // New slice enters at the top, so after NCHUNK shifts slice 0 sits at the LSB.
                sum_d   = (sum_q >> CHUNK) | (WIDTH'(slice_sum_s) << (WIDTH - CHUNK));
                carry_d = slice_cout_s;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cout_d  = slice_cout_s;
                    ovf_d   = slice_cmsb_s ^ slice_cout_s;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule
